mem_wait_ctrl: RTL and testbench

//  Parametrised successor of the 8-bit single-cycle Mem. Synchronous RAM behind a req/ready

---
 rtl/mem_wait_ctrl_if.sv | 34 +++
 rtl/mem_wait_ctrl.sv | 158 +++++++++++++++
 tb/tb_mem_wait_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wait_ctrl_if.sv
// Request/response bus between the CPU FSM and mem_wait_ctrl.
// memInjErr exists only when MEM_PARITY_EN is defined.
interface mem_wait_ctrl_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
);
   logic              memReq;
   logic              memWe;
   logic [ADDR_W-1:0] memAdr;
   logic [DATA_W-1:0] memWD;
   logic [DATA_W-1:0] memRD;
   logic              memReady;
   logic              memBusy;
   logic              memErr;
`ifdef MEM_PARITY_EN
   logic              memInjErr;
`endif

   modport master (
`ifdef MEM_PARITY_EN
      output memInjErr,
`endif
      output memReq, memWe, memAdr, memWD,
      input  memRD, memReady, memBusy, memErr
   );

   modport slave (
`ifdef MEM_PARITY_EN
      input  memInjErr,
`endif
      input  memReq, memWe, memAdr, memWD,
      output memRD, memReady, memBusy, memErr
   );
endinterface

// File: rtl/mem_wait_ctrl.sv
// Synchronous RAM behind a req/ready handshake with WAIT_STATES stall cycles and range/parity error flag.
// Optional feature macro: MEM_PARITY_EN (per-word even parity with write-side error injection).
module mem_wait_ctrl #(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 8,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 2
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   mem_wait_ctrl_if.slave bus
);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef MEM_PARITY_EN
   localparam int RAM_W = DATA_W + 1;
`else
   localparam int RAM_W = DATA_W;
`endif
   localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [3:0]        r_cnt;
   logic [3:0]        w_cnt_next;
   logic              w_accept;
   logic              w_commit;

   logic              r_we;
   logic [ADDR_W-1:0] r_adr;
   logic [DATA_W-1:0] r_wd;
   logic              w_we;
   logic [ADDR_W-1:0] w_adr;
   logic [DATA_W-1:0] w_wd;
`ifdef MEM_PARITY_EN
   logic              r_inj;
   logic              w_inj;
`endif

   logic              w_in_range;
   logic [IDX_W-1:0]  w_idx;
   logic [RAM_W-1:0]  w_wr_word;
   logic [RAM_W-1:0]  w_rd_word;
   logic              w_ram_we;
   logic [DATA_W-1:0] r_rd;
   logic              r_err;
   logic [RAM_W-1:0]  r_ram [DEPTH];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // w_commit marks the edge that enters RESP: the RAM access happens there.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_accept     = 1'b0;
      w_commit     = 1'b0;
      case (r_state)
         S_IDLE, S_RESP: begin
            if (bus.memReq) begin
               w_accept = 1'b1;
               if (WAIT_STATES > 0) begin
                  w_state_next = S_WAIT;
                  w_cnt_next   = WS_LOAD;
               end else begin
                  w_state_next = S_RESP;
                  w_commit     = 1'b1;
               end
            end else begin
               w_state_next = S_IDLE;
            end
         end
         S_WAIT: begin
            if (r_cnt == 4'd0) begin
               w_state_next = S_RESP;
               w_commit     = 1'b1;
            end else begin
               w_cnt_next = r_cnt - 4'd1;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_we  <= 1'b0;
         r_adr <= '0;
         r_wd  <= '0;
`ifdef MEM_PARITY_EN
         r_inj <= 1'b0;
`endif
      end else if (w_accept) begin
         r_we  <= bus.memWe;
         r_adr <= bus.memAdr;
         r_wd  <= bus.memWD;
`ifdef MEM_PARITY_EN
         r_inj <= bus.memInjErr;
`endif
      end
   end

   // With zero wait states the commit edge is also the accept edge, so the live bus is used.
   assign w_we  = w_accept ? bus.memWe  : r_we;
   assign w_adr = w_accept ? bus.memAdr : r_adr;
   assign w_wd  = w_accept ? bus.memWD  : r_wd;
`ifdef MEM_PARITY_EN
   assign w_inj     = w_accept ? bus.memInjErr : r_inj;
   assign w_wr_word = {(^w_wd) ^ w_inj, w_wd};
`else
   assign w_wr_word = w_wd;
`endif

   assign w_in_range = (32'(w_adr) < 32'(DEPTH));
   assign w_idx      = w_adr[IDX_W-1:0];
   assign w_rd_word  = r_ram[w_idx];
   assign w_ram_we   = i_rst_n & w_commit & w_we & w_in_range;

   always_ff @(posedge i_clk) begin
      if (w_ram_we) begin
         r_ram[w_idx] <= w_wr_word;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd  <= '0;
         r_err <= 1'b0;
      end else if (w_commit) begin
         if (!w_we) begin
            r_rd <= w_in_range ? w_rd_word[DATA_W-1:0] : '0;
         end
`ifdef MEM_PARITY_EN
         // Even parity: data plus stored bit must XOR to zero.
         r_err <= !w_in_range || (!w_we && (^w_rd_word));
`else
         r_err <= !w_in_range;
`endif
      end
   end

   assign bus.memRD    = r_rd;
   assign bus.memReady = (r_state == S_RESP);
   assign bus.memBusy  = (r_state == S_WAIT);
   assign bus.memErr   = (r_state == S_RESP) & r_err;
endmodule

// File: tb/tb_mem_wait_ctrl.sv
// Self-checking bench: three mem_wait_ctrl instances (WS=2, WS=0, DEPTH=128/WS=1) against a word-level model.
// Parity scenario runs only when MEM_PARITY_EN is defined.
module tb_mem_wait_ctrl;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int ws_of    [3] = '{2, 0, 1};
   int depth_of [3] = '{256, 256, 128};

   logic       req [3];
   logic       we  [3];
   logic [7:0] adr [3];
   logic [7:0] wd  [3];
   logic       inj [3];
   wire  [7:0] rd    [3];
   wire        ready [3];
   wire        busy  [3];
   wire        err   [3];

   // reference model: word contents, written flags, poisoned-parity flags, last read data
   logic [7:0] m_mem   [3][256];
   bit         m_valid [3][256];
   bit         m_pbad  [3][256];
   logic [7:0] m_rd    [3];

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      mem_wait_ctrl_if #(.DATA_W(8), .ADDR_W(8)) bus ();
      assign bus.memReq = req[gi];
      assign bus.memWe  = we[gi];
      assign bus.memAdr = adr[gi];
      assign bus.memWD  = wd[gi];
`ifdef MEM_PARITY_EN
      assign bus.memInjErr = inj[gi];
`endif
      assign rd[gi]    = bus.memRD;
      assign ready[gi] = bus.memReady;
      assign busy[gi]  = bus.memBusy;
      assign err[gi]   = bus.memErr;
      mem_wait_ctrl #(
         .DATA_W(8), .ADDR_W(8),
         .DEPTH(gi == 2 ? 128 : 256),
         .WAIT_STATES(gi == 0 ? 2 : (gi == 1 ? 0 : 1))
      ) u_dut (
         .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
      );
   end

   task automatic drive(input int s, input logic w, input logic [7:0] a, input logic [7:0] d, input logic j);
      req[s] = 1'b1; we[s] = w; adr[s] = a; wd[s] = d; inj[s] = j;
   endtask

   // Expected result of the access currently driven on instance s; updates the model.
   task automatic model_access(input int s, output logic [7:0] e_rd, output logic e_err);
      bit inr;
      inr = int'(adr[s]) < depth_of[s];
      if (we[s]) begin
         if (inr) begin
            m_mem[s][adr[s]]   = wd[s];
            m_valid[s][adr[s]] = 1'b1;
            m_pbad[s][adr[s]]  = inj[s];
         end
         e_err = !inr;
      end else begin
         m_rd[s] = inr ? m_mem[s][adr[s]] : 8'h00;
         e_err   = !inr || m_pbad[s][adr[s]];
      end
      e_rd = m_rd[s];
   endtask

   // One single-shot access; returns observed latency, busy cycles, response and the cycle after.
   task automatic do_access(input int s, input logic w, input logic [7:0] a, input logic [7:0] d,
                            input logic j, output int lat, output int busy_n,
                            output logic [7:0] o_rd, output logic o_err, output logic o_after,
                            output logic [7:0] e_rd, output logic e_err);
      @(negedge clk);
      drive(s, w, a, d, j);
      model_access(s, e_rd, e_err);
      @(posedge clk); #1;
      req[s] = 1'b0;
      lat    = 1;
      busy_n = 0;
      while (ready[s] !== 1'b1 && lat <= 20) begin
         if (busy[s] === 1'b1) busy_n++;
         @(posedge clk); #1;
         lat++;
      end
      o_rd  = rd[s];
      o_err = err[s];
      @(posedge clk); #1;
      o_after = ready[s] | busy[s] | err[s];
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) begin
         total++;
         if (rd[s] !== 8'h00 || ready[s] !== 1'b0 || busy[s] !== 1'b0 || err[s] !== 1'b0) begin
            bad++;
            $display("FAIL reset_state s=%0d got rd=%h rdy=%b busy=%b err=%b exp 00/0/0/0",
                     s, rd[s], ready[s], busy[s], err[s]);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_wait_states();
      int lat, bn; logic [7:0] o_rd, e_rd; logic o_err, o_after, e_err;
      do_access(0, 1'b1, 8'h10, 8'hA5, 1'b0, lat, bn, o_rd, o_err, o_after, e_rd, e_err);
      total++;
      if (lat != 3 || bn != 2 || o_err !== 1'b0 || o_after !== 1'b0) begin
         bad++;
         $display("FAIL ws2_write got lat=%0d busy=%0d err=%b after=%b exp 3/2/0/0", lat, bn, o_err, o_after);
      end
      do_access(0, 1'b0, 8'h10, 8'h00, 1'b0, lat, bn, o_rd, o_err, o_after, e_rd, e_err);
      total++;
      if (lat != 3 || bn != 2 || o_rd !== 8'hA5 || o_err !== 1'b0) begin
         bad++;
         $display("FAIL ws2_read got lat=%0d busy=%0d rd=%h err=%b exp 3/2/a5/0", lat, bn, o_rd, o_err);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] e_rd, a; logic e_err, w;
      @(negedge clk);
      drive(1, 1'b1, 8'h01, 8'h3C, 1'b0);
      model_access(1, e_rd, e_err);
      @(posedge clk); #1;
      total++;
      if (ready[1] !== 1'b1 || err[1] !== 1'b0) begin
         bad++;
         $display("FAIL b2b_write got rdy=%b err=%b exp 1/0", ready[1], err[1]);
      end
      @(negedge clk);
      drive(1, 1'b0, 8'h01, 8'h00, 1'b0);
      model_access(1, e_rd, e_err);
      @(posedge clk); #1;
      total++;
      if (ready[1] !== 1'b1 || rd[1] !== 8'h3C || err[1] !== 1'b0) begin
         bad++;
         $display("FAIL b2b_read got rdy=%b rd=%h err=%b exp 1/3c/0", ready[1], rd[1], err[1]);
      end
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         a = 8'($urandom_range(0, 7));
         w = (!m_valid[1][a]) ? 1'b1 : 1'($urandom % 2);
         drive(1, w, a, 8'($urandom), 1'b0);
         model_access(1, e_rd, e_err);
         @(posedge clk); #1;
         total++;
         if (ready[1] !== 1'b1 || rd[1] !== e_rd || err[1] !== e_err) begin
            bad++;
            $display("FAIL b2b_stream i=%0d we=%b adr=%h got rdy=%b rd=%h err=%b exp 1/%h/%b",
                     i, w, a, ready[1], rd[1], err[1], e_rd, e_err);
         end
      end
      @(negedge clk);
      req[1] = 1'b0;
      @(posedge clk); #1;
      total++;
      if (ready[1] !== 1'b0) begin
         bad++;
         $display("FAIL b2b_drop got rdy=%b exp 0", ready[1]);
      end
   endtask

   task automatic test_range();
      int lat, bn; logic [7:0] o_rd, e_rd; logic o_err, o_after, e_err;
      do_access(2, 1'b1, 8'h00, 8'h5A, 1'b0, lat, bn, o_rd, o_err, o_after, e_rd, e_err);
      do_access(2, 1'b1, 8'h80, 8'h77, 1'b0, lat, bn, o_rd, o_err, o_after, e_rd, e_err);
      total++;
      if (lat != 2 || bn != 1 || o_err !== 1'b1 || o_after !== 1'b0) begin
         bad++;
         $display("FAIL range_write got lat=%0d busy=%0d err=%b after=%b exp 2/1/1/0", lat, bn, o_err, o_after);
      end
      do_access(2, 1'b0, 8'h00, 8'h00, 1'b0, lat, bn, o_rd, o_err, o_after, e_rd, e_err);
      total++;
      if (o_rd !== 8'h5A || o_err !== 1'b0) begin
         bad++;
         $display("FAIL range_alias got rd=%h err=%b exp 5a/0", o_rd, o_err);
      end
      do_access(2, 1'b0, 8'h80, 8'h00, 1'b0, lat, bn, o_rd, o_err, o_after, e_rd, e_err);
      total++;
      if (o_rd !== 8'h00 || o_err !== 1'b1) begin
         bad++;
         $display("FAIL range_read got rd=%h err=%b exp 00/1", o_rd, o_err);
      end
   endtask

   task automatic test_abort();
      int lat, bn, pulses; logic [7:0] o_rd, e_rd; logic o_err, o_after, e_err;
      do_access(0, 1'b1, 8'h20, 8'h11, 1'b0, lat, bn, o_rd, o_err, o_after, e_rd, e_err);
      do_access(0, 1'b0, 8'h20, 8'h00, 1'b0, lat, bn, o_rd, o_err, o_after, e_rd, e_err);
      @(negedge clk);
      drive(0, 1'b1, 8'h20, 8'h55, 1'b0);
      @(posedge clk); #1;
      req[0] = 1'b0;
      total++;
      if (busy[0] !== 1'b1) begin
         bad++;
         $display("FAIL abort_busy got busy=%b exp 1", busy[0]);
      end
      #2;
      rst_n = 1'b0;
      #1;
      for (int s = 0; s < 3; s++) begin
         total++;
         if (rd[s] !== 8'h00 || ready[s] !== 1'b0 || busy[s] !== 1'b0 || err[s] !== 1'b0) begin
            bad++;
            $display("FAIL reset_async s=%0d got rd=%h rdy=%b busy=%b err=%b exp 00/0/0/0",
                     s, rd[s], ready[s], busy[s], err[s]);
         end
      end
      pulses = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (ready[0] === 1'b1) pulses++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int s = 0; s < 3; s++) m_rd[s] = 8'h00;
      @(posedge clk); #1;
      if (ready[0] === 1'b1) pulses++;
      total++;
      if (pulses != 0) begin
         bad++;
         $display("FAIL abort_pulse got pulses=%0d exp 0", pulses);
      end
      do_access(0, 1'b0, 8'h20, 8'h00, 1'b0, lat, bn, o_rd, o_err, o_after, e_rd, e_err);
      total++;
      if (o_rd !== 8'h11 || o_err !== 1'b0) begin
         bad++;
         $display("FAIL abort_keep got rd=%h err=%b exp 11/0", o_rd, o_err);
      end
   endtask

   task automatic test_random();
      int lat, bn; logic [7:0] o_rd, e_rd, a; logic o_err, o_after, e_err, w;
      for (int s = 0; s < 3; s++) begin
         for (int i = 0; i < 30; i++) begin
            a = (s == 2) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 31));
            w = 1'($urandom % 2);
            if (!w && int'(a) < depth_of[s] && !m_valid[s][a]) w = 1'b1;
            do_access(s, w, a, 8'($urandom), 1'b0, lat, bn, o_rd, o_err, o_after, e_rd, e_err);
            total++;
            if (lat != ws_of[s] + 1 || bn != ws_of[s] || o_rd !== e_rd || o_err !== e_err || o_after !== 1'b0) begin
               bad++;
               $display("FAIL random s=%0d we=%b adr=%h got lat=%0d busy=%0d rd=%h err=%b after=%b exp %0d/%0d/%h/%b/0",
                        s, w, a, lat, bn, o_rd, o_err, o_after, ws_of[s] + 1, ws_of[s], e_rd, e_err);
            end
         end
      end
   endtask

`ifdef MEM_PARITY_EN
   task automatic test_parity();
      int lat, bn; logic [7:0] o_rd, e_rd; logic o_err, o_after, e_err;
      do_access(0, 1'b1, 8'h05, 8'h0F, 1'b1, lat, bn, o_rd, o_err, o_after, e_rd, e_err);
      do_access(0, 1'b0, 8'h05, 8'h00, 1'b0, lat, bn, o_rd, o_err, o_after, e_rd, e_err);
      total++;
      if (o_rd !== 8'h0F || o_err !== 1'b1) begin
         bad++;
         $display("FAIL parity_inject got rd=%h err=%b exp 0f/1", o_rd, o_err);
      end
      do_access(0, 1'b1, 8'h05, 8'h0F, 1'b0, lat, bn, o_rd, o_err, o_after, e_rd, e_err);
      do_access(0, 1'b0, 8'h05, 8'h00, 1'b0, lat, bn, o_rd, o_err, o_after, e_rd, e_err);
      total++;
      if (o_rd !== 8'h0F || o_err !== 1'b0) begin
         bad++;
         $display("FAIL parity_clean got rd=%h err=%b exp 0f/0", o_rd, o_err);
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < 3; i++) begin
         req[i] = 1'b0; we[i] = 1'b0; adr[i] = 8'h00; wd[i] = 8'h00; inj[i] = 1'b0;
         m_rd[i] = 8'h00;
      end
      test_reset();
      test_wait_states();
      test_back_to_back();
      test_range();
      test_abort();
      test_random();
`ifdef MEM_PARITY_EN
      test_parity();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
